// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the step counter: it only has to reach WIDTH-1.
  function automatic int count_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division step: shift {rem, sr} left, trial subtract, select.
module seq_div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] sr_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] sr_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           q_bit;

  // rem_i < divisor_i holds between steps (or the divisor is zero and the
  // shifted value never exceeds WIDTH bits), so bit WIDTH of the WIDTH+1 bit
  // trial difference is a reliable sign bit.
  always_comb begin
    shifted = {rem_i, sr_i[WIDTH-1]};
    trial   = shifted - {1'b0, divisor_i};
    q_bit   = ~trial[WIDTH];
    rem_o   = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    sr_o    = {sr_i[WIDTH-2:0], q_bit};
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Define SEQ_DIVIDER_DIVZERO_EN to short-circuit a zero divisor with div_by_zero=1.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = count_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] res_rem_q, res_rem_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_sr;
  logic             zero_skip;
  logic             dbz_set;

  seq_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .sr_i      (sr_q),
    .divisor_i (div_q),
    .rem_o     (step_rem),
    .sr_o      (step_sr)
  );

`ifdef SEQ_DIVIDER_DIVZERO_EN
  logic dbz_q, dbz_d;

  // On the first CALC edge sr_q still holds the untouched dividend.
  assign zero_skip = (count_q == '0) && (div_q == '0);

  always_comb begin
    dbz_d = dbz_q;
    if (dbz_set) begin
      dbz_d = zero_skip;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbz_q <= 1'b0;
    end else begin
      dbz_q <= dbz_d;
    end
  end

  assign div_by_zero = dbz_q;
`else
  assign zero_skip   = 1'b0;
  assign div_by_zero = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    sr_d      = sr_q;
    div_d     = div_q;
    quot_d    = quot_q;
    res_rem_d = res_rem_q;
    done_d    = 1'b0;
    dbz_set   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          div_d   = divisor;
          rem_d   = '0;
          sr_d    = dividend;
          count_d = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (zero_skip) begin
          quot_d    = '1;
          res_rem_d = sr_q;
          done_d    = 1'b1;
          dbz_set   = 1'b1;
          state_d   = DONE;
        end else begin
          rem_d   = step_rem;
          sr_d    = step_sr;
          count_d = count_q + CW'(1);
          if (count_q == LAST) begin
            quot_d    = step_sr;
            res_rem_d = step_rem;
            done_d    = 1'b1;
            dbz_set   = 1'b1;
            state_d   = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      rem_q     <= '0;
      sr_q      <= '0;
      div_q     <= '0;
      quot_q    <= '0;
      res_rem_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      sr_q      <= sr_d;
      div_q     <= div_d;
      quot_q    <= quot_d;
      res_rem_q <= res_rem_d;
      done_q    <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = res_rem_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus random operands
// compared against plain integer division.
module tb_seq_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int compared   = 0;
  int mismatched = 0;
  int cycle      = 0;
  int done_cnt   = 0;

  // Expected {div_by_zero, quotient, remainder} per launched division.
  logic [2*W:0] exp_q[$];

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Clock / cycle bookkeeping
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Reference: plain division; zero divisor gives all-ones / dividend.
  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    q = (b == 0) ? {W{1'b1}} : a / b;
    r = (b == 0) ? a : a % b;
`ifdef SEQ_DIVIDER_DIVZERO_EN
    z = (b == 0);
`else
    z = 1'b0;
`endif
    return {z, q, r};
  endfunction

  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag, output int done_at);
    logic [2*W:0] e;
    int n;
    int lat;
    exp_q.push_back(model(a, b));
`ifdef SEQ_DIVIDER_DIVZERO_EN
    lat = (b == 0) ? 1 : W;
`else
    lat = W;
`endif
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    check({tag, "_busy_calc"}, 32'(busy), 32'd1);
    wait_done(n);
    check({tag, "_latency"}, 32'(n), 32'(lat));
    e = exp_q.pop_front();
    check({tag, "_quotient"}, 32'(quotient), 32'(e[2*W-1:W]));
    check({tag, "_remainder"}, 32'(remainder), 32'(e[W-1:0]));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(e[2*W]));
    done_at = cycle;
    @(posedge clk);
    #1;
    check({tag, "_done_low"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int t1, t2, n, base;
    logic [W-1:0] a, b;
    int sel;

    // Reset state
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quot", 32'(quotient), 32'd0);
    check("rst_rem", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    reset = 1'b0;

    // Basic cases
    do_div(16'd100, 16'd7, "d100_7", t1);
    do_div(16'hFFFF, 16'd1, "dffff_1", t1);
    do_div(16'd5, 16'd9, "d5_9", t2);
    check("b2b_spacing_a", 32'(t2 - t1), 32'(W + 2));
    do_div(16'd1234, 16'd0, "d1234_0", t1);

    // Start ignored while busy; operands changed mid-run
    base = done_cnt;
    @(negedge clk);
    start = 1'b1; dividend = 16'd100; divisor = 16'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 16'd50; divisor = 16'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("ign_quotient", 32'(quotient), 32'd14);
    check("ign_remainder", 32'(remainder), 32'd2);
    repeat (20) @(posedge clk);
    #1;
    check("ign_done_once", 32'(done_cnt - base), 32'd1);
    check("ign_idle", 32'(busy), 32'd0);

    // Reset mid-calculation
    base = done_cnt;
    @(negedge clk);
    start = 1'b1; dividend = 16'd100; divisor = 16'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_quot", 32'(quotient), 32'd0);
    check("midrst_rem", 32'(remainder), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("midrst_no_done", 32'(done_cnt - base), 32'd0);
    do_div(16'd50, 16'd5, "after_rst", t1);

    // Back-to-back throughput
    do_div(16'd1000, 16'd3, "b2b_1", t1);
    do_div(16'd65535, 16'd255, "b2b_2", t2);
    check("b2b_spacing_b", 32'(t2 - t1), 32'(W + 2));

    // Random operands
    for (int i = 0; i < 24; i++) begin
      a = W'($urandom_range(0, 65535));
      sel = $urandom_range(0, 7);
      if (sel == 0)      b = '0;
      else if (sel == 1) b = W'($urandom_range(1, 15));
      else if (sel == 2) b = W'($urandom_range(32768, 65535));
      else               b = W'($urandom_range(1, 65535));
      do_div(a, b, "rand", t1);
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter WIDTH, default 16, operand, quotient and remainder width in bits; WIDTH SHALL be at least 2.
REQ-002 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-high reset.
REQ-004 Port start, input, 1: request a division; sampled only when idle.
REQ-005 Port dividend, input, WIDTH: unsigned dividend; captured on the accepted start edge.
REQ-006 Port divisor, input, WIDTH: unsigned divisor; captured on the accepted start edge.
REQ-007 Port busy, output, 1: high while a division is in progress (CALC or DONE).
REQ-008 Port done, output, 1: registered one-cycle completion pulse.
REQ-009 Port quotient, output, WIDTH: registered result; held until the next completion.
REQ-010 Port remainder, output, WIDTH: registered result; held until the next completion.
REQ-011 Port div_by_zero, output, 1: registered error flag; held until the next completion.

Function
REQ-012 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-013 In IDLE with start=1 at edge E0, the block SHALL capture both operands, clear the partial remainder, load the shift register with the dividend, set count to 0 and enter CALC.
REQ-014 Each CALC edge SHALL perform one restoring step:
- shift {partial remainder, shift register} left by one;
- trial = partial remainder - divisor, computed in WIDTH+1 bits;
- if the trial is non-negative, the partial remainder SHALL take the trial value and the new quotient LSB SHALL be 1; otherwise the remainder is restored and the LSB SHALL be 0.
REQ-015 CALC SHALL last exactly WIDTH edges (E1..E16 for WIDTH=16); at edge E_WIDTH the block SHALL register quotient and remainder, enter DONE and drive done=1.
REQ-016 DONE SHALL last exactly one cycle, then return to IDLE with done=0.
REQ-017 Latency SHALL be fixed: done is high in the cycle following edge E_WIDTH, independent of operand values.
REQ-018 start SHALL be ignored in CALC and in DONE; operand changes after E0 SHALL have no effect on the result.
REQ-019 busy SHALL equal (state != IDLE).
REQ-020 A new start SHALL be accepted in the first IDLE cycle after DONE, giving back-to-back throughput of one result per WIDTH+2 cycles.
REQ-021 With divisor=0 and no special handling, the algorithm SHALL naturally yield quotient all-ones and remainder=dividend.

Reset
REQ-022 While reset=1:
- state=IDLE and count=0;
- busy=0, done=0 and div_by_zero=0;
- quotient=0 and remainder=0;
- internal registers cleared.
REQ-023 Reset asserted mid-CALC SHALL abort the operation with no done pulse; the first start after reset release SHALL behave per REQ-013.

Configuration
REQ-024 Macro SEQ_DIVIDER_DIVZERO_EN, when defined, SHALL make a zero divisor captured at E0 skip CALC and enter DONE at edge E1, with:
- quotient all-ones;
- remainder=dividend;
- div_by_zero=1.
REQ-025 With SEQ_DIVIDER_DIVZERO_EN undefined, a zero divisor SHALL run the full WIDTH-step sequence per REQ-021, and div_by_zero SHALL be tied to 0.

Structure
REQ-026 A shared package seq_divider_pkg SHALL hold the state enum type (IDLE, CALC, DONE) and the default width constant.
REQ-027 The restoring step (shift, trial subtract, select) SHALL be a combinational sub-module named seq_div_step, instantiated once inside seq_divider.

Verification
REQ-028 Start with dividend=100 and divisor=7 -> done in the 17th cycle after the start edge; quotient=14, remainder=2, div_by_zero=0.
REQ-029 Start with dividend=16'hFFFF and divisor=1 -> quotient=16'hFFFF, remainder=0; then dividend=5 and divisor=9 -> quotient=0, remainder=5.
REQ-030 Start with dividend=1234 and divisor=0:
- with the macro defined -> done at edge E1, quotient=16'hFFFF, remainder=1234, div_by_zero=1;
- with the macro undefined -> done at edge E16, same quotient and remainder, div_by_zero=0.
REQ-031 Start with 100/7, then pulse start with 50/5 at cycle 5 and change operands -> second start ignored; result quotient=14, remainder=2, done pulse exactly once.
REQ-032 Start with 100/7, assert reset at cycle 8 -> busy, done, quotient and remainder all 0 immediately and no done pulse; after release, 50/5 -> quotient=10, remainder=0.
REQ-033 Two back-to-back divisions (start reasserted in the first IDLE cycle after done) -> both results correct, with done pulses WIDTH+2 cycles apart.
